dds_reg_write_arbiter: RTL
==========================

Name: dds_reg_write_arbiter

Overview:
Shares the single AD9910 SPI register-write path between NUM_REQ requesters, e.g. the UART command decoder and a sweep sequencer. It accepts one register write per requester handshake, picks requesters round-robin, and drives one transaction at a time into the SPI master. After a write, and only if the requester asked for it, it pulses the DDS IO_UPDATE pin. It sits between the command/sweep logic and the SPI master inside the DDS control top level.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 64, max register payload width in bits (AD9910 max 8 bytes)
IO_UPD_CYC, 4, IO_UPDATE high time in sys_clk cycles (>=1)
UPD_GAP_CYC, 2, idle cycles between SPI done and IO_UPDATE rise (>=0)
TIMEOUT_CYC, 65535, watchdog limit in cycles on spi_done (used only with DDS_WR_TIMEOUT_EN)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept, one-hot, one cycle
req_addr  in  NUM_REQ*8  register address, requester i at [8i+7:8i]
req_data  in  NUM_REQ*DATA_W  payload, MSB-aligned, requester i at slice i
req_len  in  NUM_REQ*4  payload byte count
req_upd  in  NUM_REQ  1 = pulse IO_UPDATE after this write
spi_start  out  1  one-cycle start strobe to SPI master
spi_addr  out  8  latched address
spi_data  out  DATA_W  latched payload
spi_len  out  4  latched, clamped byte count
spi_done  in  1  one-cycle completion from SPI master
io_update  out  1  DDS IO_UPDATE pin
grant_id  out  clog2(NUM_REQ) (min 1)  index of current or last granted requester
busy  out  1  high in every state except IDLE
wr_err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, all outputs 0.
- The bench drives inputs synchronous to sys_clk.
- State machine:
  - IDLE: if any req_valid, go to GRANT.
  - GRANT: round-robin pick. Search starts at rr_ptr, which is last grant + 1 mod NUM_REQ. In the same cycle: assert req_ready[g], latch addr/data/len/upd of g, set grant_id=g, rr_ptr<=g+1 mod NUM_REQ, go to START. Transfer happens when valid&ready are both high; the requester must hold its inputs stable until ready.
  - START: spi_start=1 for exactly one cycle, go to WAIT.
  - WAIT: on spi_done, go to GAP if latched upd=1, else IDLE.
  - GAP: count UPD_GAP_CYC cycles, then go to PULSE. If UPD_GAP_CYC=0, go to PULSE immediately.
  - PULSE: io_update=1 for IO_UPD_CYC cycles, then go to IDLE.
- Latency: valid rising in IDLE gives ready on the next cycle and spi_start one cycle after that.
- A back-to-back request re-arbitrates only after IDLE. Minimum spacing is 1 idle cycle.
- Length rule: len 0 or len >8 is clamped to 8. spi_len is always in 1..8.
- spi_addr/spi_data/spi_len are held constant from GRANT until the next GRANT.
- A request dropped (valid falling) before ready is ignored; no error.
- spi_done seen outside WAIT is ignored.
- Simultaneous requests: only one ready per grant. Losers keep waiting and get served next, so there is no starvation; worst-case wait is NUM_REQ-1 transactions.
- Reset mid-transaction: immediate IDLE, io_update drops at once, latched request discarded.

Optional Feature:
DDS_WR_TIMEOUT_EN
- Defined: WAIT has a counter. If spi_done does not arrive within TIMEOUT_CYC cycles, set wr_err=1 (sticky until reset), skip IO_UPDATE and go to IDLE.
- Not defined: WAIT waits forever, no counter logic is built, and wr_err is tied 0.

Decomposition:
- Package dds_ctrl_pkg holds: state enum (IDLE, GRANT, START, WAIT, GAP, PULSE), DDS_MAX_BYTES=8, AD9910 address constants (CFR1=8'h00, CFR2=8'h01, STP0=8'h0E).
- One sub-module: rr_arbiter (NUM_REQ-wide combinational round-robin pick from the valid mask and rr_ptr, outputs a one-hot grant and its index).
- The FSM, request latches, and counters stay in the top module.

Test Plan:
- Single request: req0 addr=8'h0E, len=8, data=64'h3FFF_0000_1999_999A, upd=1. Expect ready0 for 1 cycle, then spi_start on the next cycle with those values. Drive spi_done 100 cycles later; io_update must rise 2 cycles after done and stay high 4 cycles; busy low after.
- Contention: req0 and req1 valid on the same cycle, rr_ptr=0. Grant order must be 0, 1, 0, 1 over 4 back-to-back writes, with exactly one ready per grant.
- Length clamp: len=0 gives spi_len=8; len=4'hF gives spi_len=8; len=2 gives spi_len=2.
- No update: upd=0. After spi_done the block returns to IDLE the next cycle; io_update never asserts.
- Reset mid-operation: deassert sys_rst_n during PULSE. io_update and busy go 0 asynchronously; after release, a pending req1 is granted normally.
- With DDS_WR_TIMEOUT_EN and TIMEOUT_CYC=16: withhold spi_done. wr_err must be 1 after 16 WAIT cycles, io_update must stay 0, and the state must return to IDLE.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// Shared state encoding, AD9910 constants and small helpers for the DDS
// register-write path.
package dds_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4,
    PULSE = 3'd5
  } dds_wr_state_e;

  localparam int DDS_MAX_BYTES = 8;

  localparam logic [7:0] AD9910_CFR1 = 8'h00;
  localparam logic [7:0] AD9910_CFR2 = 8'h01;
  localparam logic [7:0] AD9910_STP0 = 8'h0E;

  // A zero or oversize byte count means "full 8-byte register".
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    logic [3:0] max_len;
    max_len = 4'(DDS_MAX_BYTES);
    if ((len == 4'd0) || (len > max_len)) begin
      clamp_len = max_len;
    end else begin
      clamp_len = len;
    end
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dds_reg_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr and wraps, returning a
// one-hot grant, its index and whether anything was valid.
module rr_arbiter
  import dds_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] grant_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   rot_onehot;
  logic                 found;
  int                   pos;

  // Rotate so bit 0 is the ptr position, take the first set bit, rotate back.
  always_comb begin
    dbl        = {valid, valid};
    rot        = NUM_REQ'(dbl >> ptr);
    rot_onehot = '0;
    found      = 1'b0;
    pos        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        rot_onehot[k] = 1'b1;
        pos           = k;
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
    grant_dbl = {{NUM_REQ{1'b0}}, rot_onehot} << ptr;
    grant     = grant_dbl[NUM_REQ-1:0] | grant_dbl[2*NUM_REQ-1:NUM_REQ];
    idx       = IDX_W'((int'(ptr) + pos) % NUM_REQ);
    any       = found;
  end

endmodule

// File: rtl/dds_reg_write_arbiter.sv
// Round-robin arbiter sharing the AD9910 SPI register-write path, with an
// optional IO_UPDATE pulse per write. Optional SPI watchdog: DDS_WR_TIMEOUT_EN.
module dds_reg_write_arbiter
  import dds_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 64,
  parameter int IO_UPD_CYC  = 4,
  parameter int UPD_GAP_CYC = 2,
  parameter int TIMEOUT_CYC = 65535,
  localparam int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*8-1:0]        req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*4-1:0]        req_len,
  input  logic [NUM_REQ-1:0]          req_upd,
  output logic                        spi_start,
  output logic [7:0]                  spi_addr,
  output logic [DATA_W-1:0]           spi_data,
  output logic [3:0]                  spi_len,
  input  logic                        spi_done,
  output logic                        io_update,
  output logic [GID_W-1:0]            grant_id,
  output logic                        busy,
  output logic                        wr_err
);

`ifdef DDS_WR_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  // One shared counter serves the gap, the pulse and (optionally) the watchdog.
  localparam int TO_SPAN = TIMEOUT_EN ? TIMEOUT_CYC : 1;
  localparam int CNT_MAX = max_int(max_int(IO_UPD_CYC, UPD_GAP_CYC), TO_SPAN);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  dds_wr_state_e      state_r;
  logic [GID_W-1:0]   rr_ptr_r;
  logic               upd_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [NUM_REQ-1:0] pick_grant;
  logic [GID_W-1:0]   pick_idx;
  logic               pick_any;

  logic [7:0]         sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [3:0]         sel_len;
  logic               sel_upd;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // AND-OR mux of the winning requester's fields (grant is one-hot).
  always_comb begin
    sel_addr = 8'h00;
    sel_data = '0;
    sel_len  = 4'h0;
    sel_upd  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | ({8{pick_grant[i]}} & req_addr[8*i +: 8]);
      sel_data = sel_data | ({DATA_W{pick_grant[i]}} & req_data[DATA_W*i +: DATA_W]);
      sel_len  = sel_len  | ({4{pick_grant[i]}} & req_len[4*i +: 4]);
      sel_upd  = sel_upd  | (pick_grant[i] & req_upd[i]);
    end
  end

`ifndef DDS_WR_TIMEOUT_EN
  assign wr_err = 1'b0;
`endif

  // Transaction FSM: pick on the way into GRANT so ready and the latched
  // request come straight from registers during GRANT.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      upd_r     <= 1'b0;
      cnt_r     <= '0;
      req_ready <= '0;
      spi_start <= 1'b0;
      spi_addr  <= 8'h00;
      spi_data  <= '0;
      spi_len   <= 4'h0;
      io_update <= 1'b0;
      grant_id  <= '0;
      busy      <= 1'b0;
`ifdef DDS_WR_TIMEOUT_EN
      wr_err    <= 1'b0;
`endif
    end else begin
      spi_start <= 1'b0;
      req_ready <= '0;
      case (state_r)
        IDLE: begin
          if (pick_any) begin
            state_r   <= GRANT;
            busy      <= 1'b1;
            req_ready <= pick_grant;
            grant_id  <= pick_idx;
            spi_addr  <= sel_addr;
            spi_data  <= sel_data;
            spi_len   <= clamp_len(sel_len);
            upd_r     <= sel_upd;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          // A requester that dropped valid during GRANT is not served.
          if (|(req_valid & req_ready)) begin
            state_r   <= START;
            spi_start <= 1'b1;
            rr_ptr_r  <= (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + GID_W'(1);
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        START: begin
          state_r <= WAIT;
          cnt_r   <= '0;
        end
        WAIT: begin
          if (spi_done) begin
            cnt_r <= '0;
            if (!upd_r) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else if (UPD_GAP_CYC == 0) begin
              state_r   <= PULSE;
              io_update <= 1'b1;
            end else begin
              state_r <= GAP;
            end
          end
`ifdef DDS_WR_TIMEOUT_EN
          else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
            wr_err  <= 1'b1;
            state_r <= IDLE;
            busy    <= 1'b0;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
`else
          else begin
            state_r <= WAIT;
          end
`endif
        end
        GAP: begin
          if (cnt_r == CNT_W'(UPD_GAP_CYC - 1)) begin
            state_r   <= PULSE;
            io_update <= 1'b1;
            cnt_r     <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_r == CNT_W'(IO_UPD_CYC - 1)) begin
            state_r   <= IDLE;
            io_update <= 1'b0;
            busy      <= 1'b0;
            cnt_r     <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          io_update <= 1'b0;
          busy      <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

endmodule
